mux_21_arbiter: RTL and testbench
=================================

Name: mux_21_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 2:1 mux datapath. Two requesters, A and B, compete for a single registered output channel.
- The arbiter owns the mux select. It holds the grant for a whole burst, meaning until the requester's last beat or until MAX_BURST beats have passed.
- The output channel uses a valid/ready handshake toward the downstream consumer.

Parameters:
- WIDTH, 8, data width of in_a, in_b and out.
- MAX_BURST, 16, maximum beats per grant before release is forced (must be ≥1).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_a  input  1  requester A wants or holds the channel; must stay high for the whole burst.
- in_a  input  WIDTH  requester A data beat.
- last_a  input  1  marks A's current beat as the final beat of its burst.
- ack_a  output  1  A's beat is accepted this cycle (combinational).
- req_b, in_b, last_b, ack_b  same as the A ports, for requester B.
- sel  output  1  registered mux select: 0 = A, 1 = B; valid while busy.
- busy  output  1  high while a grant is active.
- out  output  WIDTH  registered output data.
- out_valid  output  1  out holds an unconsumed beat.
- out_ready  input  1  downstream accepts out this cycle.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, sel=0, busy=0, out=0, out_valid=0, beat_cnt=0.
  - Round-robin pointer set so that A wins the first contention.
- States: IDLE, GRANT_A, GRANT_B.
- IDLE:
  - Only req_a → GRANT_A next cycle. Only req_b → GRANT_B.
  - Both → the requester not served most recently.
  - Neither → stay in IDLE.
  - sel and busy update on that same edge. No ack is issued in IDLE.
- GRANT_x:
  - Beat transfer condition: ack_x = req_x & (~out_valid | out_ready).
  - On ack_x: out<=in_x, out_valid<=1, beat_cnt<=beat_cnt+1.
- Output buffer:
  - If out_ready & out_valid with no ack that cycle → out_valid<=0.
  - Simultaneous pop and ack → out_valid stays 1 and out takes the new beat (full throughput, one beat per cycle).
- Burst end (IDLE on the next edge; pointer records x as last served; beat_cnt<=0; busy<=0; sel holds its value) when any of:
  - ack_x & last_x;
  - ack_x & beat_cnt==MAX_BURST-1 (forced release; rest of burst must re-arbitrate);
  - req_x==0 while in GRANT_x (burst abort; no ack that cycle).
- Ungranted requester: ack is always 0. Its req may stay high and it wins the next IDLE arbitration if contended.
- Latency:
  - req at edge n in IDLE → grant at n+1 → first ack in cycle n+1 → out_valid at n+2.
  - Minimum one IDLE cycle between consecutive grants.
- Downstream stall: out_valid=1 & out_ready=0 → ack=0, state and beat_cnt hold, out stable.
- Reset mid-burst: immediate return to reset values. The buffered beat is discarded.
- Beat counter is width clog2(MAX_BURST)+1 and never wraps.

Test Plan:
- Reset then req_a=1, in_a=8'h11, last_a=1, out_ready=1 → sel=0 and ack_a=1 in cycle 2; out=8'h11, out_valid=1 in cycle 3; state returns to IDLE.
- req_a=req_b=1 continuously, each sending single-beat bursts with last=1 → grants alternate A,B,A,B; out sequence follows in_a/in_b; one IDLE gap between grants.
- A sends a 20-beat burst, last_a never set, MAX_BURST=16 → exactly 16 acks, release; B (pending) granted next; A re-granted afterwards.
- During an A burst, out_ready=0 for 3 cycles → out and out_valid frozen, ack_a=0, no beat lost or duplicated; resumes on out_ready=1.
- req_b drops after 2 accepted beats of a 5-beat burst → abort to IDLE, out_valid drains, pointer favours A next.
- rst_n pulsed low mid-burst (asynchronous, between edges) → out_valid=0, busy=0, sel=0 immediately; first post-reset contention granted to A.

Source files
------------

// File: rtl/mux_21_arbiter_if.sv
// mux_21_arbiter_if: requester beats, grant status and registered output channel
// shared between the two requesters, the arbiter and the downstream consumer.
interface mux_21_arbiter_if #(parameter int WIDTH = 8);
    logic req_a, last_a, ack_a;
    logic req_b, last_b, ack_b;
    logic sel, busy, out_valid, out_ready;
    logic [WIDTH-1:0] in_a, in_b, out;
    modport master(
        output req_a, in_a, last_a, req_b, in_b, last_b, out_ready,
        input  ack_a, ack_b, sel, busy, out, out_valid
    );
    modport slave(
        input  req_a, in_a, last_a, req_b, in_b, last_b, out_ready,
        output ack_a, ack_b, sel, busy, out, out_valid
    );
endinterface

// File: rtl/mux_21_arbiter.sv
// mux_21_arbiter: round-robin burst arbiter driving a registered 2:1 mux output
// with a valid/ready handshake toward the consumer.
module mux_21_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 16
) (
    input logic clk,
    input logic rst_n,
    mux_21_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_BURST) + 1;
    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;
    state_t state;
    logic sel, busy, out_valid, prev_b;
    logic [WIDTH-1:0] out, din;
    logic [CW-1:0] beat_cnt;
    logic can_push, ack_a, ack_b, ack, req_g, last_g, done, pick_b;
    assign can_push = ~out_valid | bus.out_ready;
    assign ack_a    = (state == GRANT_A) & bus.req_a & can_push;
    assign ack_b    = (state == GRANT_B) & bus.req_b & can_push;
    assign ack      = ack_a | ack_b;
    assign din      = (state == GRANT_B) ? bus.in_b : bus.in_a;
    assign req_g    = (state == GRANT_B) ? bus.req_b : bus.req_a;
    assign last_g   = (state == GRANT_B) ? bus.last_b : bus.last_a;
    assign done     = ~req_g | (ack & (last_g | (beat_cnt == CW'(MAX_BURST - 1))));
    assign pick_b   = bus.req_b & (~bus.req_a | ~prev_b);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 1'b0;
            busy      <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            beat_cnt  <= '0;
            prev_b    <= 1'b1;  // B counts as last served so A wins the first contention
        end else begin
            if (ack) begin
                out       <= din;
                out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid <= 1'b0;
            end
            if (state == IDLE) begin
                if (bus.req_a | bus.req_b) begin
                    state <= pick_b ? GRANT_B : GRANT_A;
                    sel   <= pick_b;
                    busy  <= 1'b1;
                end
            end else if (done) begin
                state    <= IDLE;
                busy     <= 1'b0;
                beat_cnt <= '0;
                prev_b   <= (state == GRANT_B);
            end else if (ack) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end
    assign bus.ack_a     = ack_a;
    assign bus.ack_b     = ack_b;
    assign bus.sel       = sel;
    assign bus.busy      = busy;
    assign bus.out       = out;
    assign bus.out_valid = out_valid;
endmodule

// File: tb/tb_mux_21_arbiter.sv
// tb_mux_21_arbiter: directed scenarios plus randomized traffic checked against
// a transaction-level model of grants, bursts and the one-entry output buffer.
module tb_mux_21_arbiter;
    localparam int W  = 8;
    localparam int MB = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int pass_n = 0;
    int total_n = 0;
    mux_21_arbiter_if #(.WIDTH(W)) bus();
    mux_21_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    // model: owner -1 = nobody, 0 = A, 1 = B
    int owner, beats, served;
    logic m_sel, m_ov;
    logic [W-1:0] m_out;
    logic m_ack [2];
    function automatic logic rq(int i);
        return i == 1 ? bus.req_b : bus.req_a;
    endfunction
    function automatic logic lst(int i);
        return i == 1 ? bus.last_b : bus.last_a;
    endfunction
    function automatic logic [W-1:0] dat(int i);
        return i == 1 ? bus.in_b : bus.in_a;
    endfunction
    function void model_reset();
        owner = -1; beats = 0; served = 1; m_sel = 0; m_ov = 0; m_out = '0;
    endfunction
    function void model_comb();
        for (int i = 0; i < 2; i++) m_ack[i] = (owner == i) && rq(i) && (!m_ov || bus.out_ready);
    endfunction
    function void model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (owner >= 0 && m_ack[owner]) begin
            m_out = dat(owner);
            m_ov = 1;
        end else if (bus.out_ready) m_ov = 0;
        if (owner < 0) begin
            if (bus.req_a || bus.req_b) begin
                owner = (bus.req_a && bus.req_b) ? 1 - served : (bus.req_b ? 1 : 0);
                m_sel = owner[0];
            end
        end else if (!rq(owner) || (m_ack[owner] && (lst(owner) || beats + 1 == MB))) begin
            served = owner;
            owner = -1;
            beats = 0;
        end else if (m_ack[owner]) beats++;
    endfunction
    task automatic tick();
        model_comb();
        @(posedge clk);
        model_edge();
        #1;
    endtask
    task automatic idle_inputs();
        bus.req_a = 0; bus.req_b = 0; bus.last_a = 0; bus.last_b = 0;
        bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.req_a = 1;
        rst_n = 0;
        tick(); tick();
        total_n++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", bus.busy); else pass_n++;
        total_n++; if (bus.sel !== 1'b0) $display("FAIL reset_sel got %0b want 0", bus.sel); else pass_n++;
        total_n++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); else pass_n++;
        total_n++; if (bus.out !== 8'h00) $display("FAIL reset_out got %0h want 0", bus.out); else pass_n++;
        total_n++; if (bus.ack_a !== 1'b0) $display("FAIL reset_ack_a got %0b want 0", bus.ack_a); else pass_n++;
        bus.req_a = 0;
        rst_n = 1;
        tick();
    endtask

    task automatic test_single();
        bus.req_a = 1; bus.in_a = 8'h11; bus.last_a = 1;
        #1;
        total_n++; if (bus.ack_a !== 1'b0) $display("FAIL single_idle_ack got %0b want 0", bus.ack_a); else pass_n++;
        tick();
        total_n++; if ({bus.busy, bus.sel, bus.ack_a} !== 3'b101) $display("FAIL single_grant busy/sel/ack got %b want 101", {bus.busy, bus.sel, bus.ack_a}); else pass_n++;
        tick();
        total_n++; if ({bus.out_valid, bus.out} !== {1'b1, 8'h11}) $display("FAIL single_out got %b/%0h want 1/11", bus.out_valid, bus.out); else pass_n++;
        total_n++; if (bus.busy !== 1'b0) $display("FAIL single_release got %0b want 0", bus.busy); else pass_n++;
        bus.req_a = 0; bus.last_a = 0;
        tick();
        total_n++; if (bus.out_valid !== 1'b0) $display("FAIL single_drain got %0b want 0", bus.out_valid); else pass_n++;
    endtask

    task automatic test_alternate();
        logic want;
        want = 1;  // A was served last, so B wins first
        bus.req_a = 1; bus.req_b = 1; bus.last_a = 1; bus.last_b = 1;
        bus.in_a = 8'hA5; bus.in_b = 8'h5B;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (t % 2 == 0) begin
                total_n++; if ({bus.busy, bus.sel} !== {1'b1, want}) $display("FAIL alt_grant t=%0d got %b%b want 1%b", t, bus.busy, bus.sel, want); else pass_n++;
            end else begin
                total_n++; if ({bus.busy, bus.out} !== {1'b0, want ? 8'h5B : 8'hA5}) $display("FAIL alt_beat t=%0d got %b/%0h want 0/%0h", t, bus.busy, bus.out, want ? 8'h5B : 8'hA5); else pass_n++;
                want = ~want;
            end
        end
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_max_burst();
        int acks;
        acks = 0;
        bus.req_a = 1; bus.last_b = 1; bus.in_b = 8'hBB;
        tick();
        bus.req_b = 1;
        for (int k = 0; k < 40; k++) begin
            bus.in_a = 8'(acks);
            #1;
            if (bus.ack_a) acks++;
            tick();
            if (!bus.busy) break;
        end
        total_n++; if (acks !== 16) $display("FAIL max_burst_acks got %0d want 16", acks); else pass_n++;
        total_n++; if (bus.out !== 8'd15) $display("FAIL max_burst_last got %0h want 0f", bus.out); else pass_n++;
        tick();
        total_n++; if ({bus.busy, bus.sel} !== 2'b11) $display("FAIL max_burst_b_next got %b want 11", {bus.busy, bus.sel}); else pass_n++;
        tick();
        total_n++; if ({bus.busy, bus.out} !== {1'b0, 8'hBB}) $display("FAIL max_burst_b_beat got %b/%0h want 0/bb", bus.busy, bus.out); else pass_n++;
        tick();
        total_n++; if ({bus.busy, bus.sel} !== 2'b10) $display("FAIL max_burst_a_again got %b want 10", {bus.busy, bus.sel}); else pass_n++;
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_stall();
        bus.req_a = 1;
        tick();
        bus.in_a = 8'd1; tick();
        bus.in_a = 8'd2; tick();
        bus.out_ready = 0; bus.in_a = 8'd3;
        for (int s = 0; s < 3; s++) begin
            #1;
            total_n++; if (bus.ack_a !== 1'b0) $display("FAIL stall_ack s=%0d got %0b want 0", s, bus.ack_a); else pass_n++;
            tick();
            total_n++; if ({bus.busy, bus.out_valid, bus.out} !== {2'b11, 8'd2}) $display("FAIL stall_hold s=%0d got %b%b/%0h want 11/2", s, bus.busy, bus.out_valid, bus.out); else pass_n++;
        end
        bus.out_ready = 1;
        #1;
        total_n++; if (bus.ack_a !== 1'b1) $display("FAIL stall_resume_ack got %0b want 1", bus.ack_a); else pass_n++;
        tick();
        total_n++; if (bus.out !== 8'd3) $display("FAIL stall_resume_out got %0h want 3", bus.out); else pass_n++;
        bus.in_a = 8'd4; bus.last_a = 1;
        tick();
        total_n++; if ({bus.busy, bus.out} !== {1'b0, 8'd4}) $display("FAIL stall_end got %b/%0h want 0/4", bus.busy, bus.out); else pass_n++;
        idle_inputs();
        tick();
    endtask

    task automatic test_abort();
        bus.req_b = 1;
        tick();
        bus.in_b = 8'h21; tick();
        bus.in_b = 8'h22; tick();
        bus.req_b = 0;
        #1;
        total_n++; if (bus.ack_b !== 1'b0) $display("FAIL abort_ack got %0b want 0", bus.ack_b); else pass_n++;
        tick();
        total_n++; if ({bus.busy, bus.out_valid, bus.out} !== {2'b00, 8'h22}) $display("FAIL abort_idle got %b%b/%0h want 00/22", bus.busy, bus.out_valid, bus.out); else pass_n++;
        bus.req_a = 1; bus.req_b = 1;
        tick();
        total_n++; if ({bus.busy, bus.sel} !== 2'b10) $display("FAIL abort_a_next got %b want 10", {bus.busy, bus.sel}); else pass_n++;
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_async_reset();
        bus.req_b = 1;
        tick();
        bus.in_b = 8'h77; tick();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        total_n++; if ({bus.busy, bus.sel, bus.out_valid} !== 3'b000) $display("FAIL async_reset got %b want 000", {bus.busy, bus.sel, bus.out_valid}); else pass_n++;
        @(posedge clk); #1;
        rst_n = 1;
        bus.req_a = 1; bus.req_b = 1;
        tick();
        total_n++; if ({bus.busy, bus.sel} !== 2'b10) $display("FAIL async_first_grant got %b want 10", {bus.busy, bus.sel}); else pass_n++;
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.req_a = $urandom_range(0, 3) != 0;
            bus.req_b = $urandom_range(0, 3) != 0;
            bus.last_a = $urandom_range(0, 5) == 0;
            bus.last_b = $urandom_range(0, 5) == 0;
            bus.out_ready = $urandom_range(0, 3) != 0;
            bus.in_a = 8'($urandom);
            bus.in_b = 8'($urandom);
            #1;
            model_comb();
            total_n++; if ({bus.ack_a, bus.ack_b} !== {m_ack[0], m_ack[1]}) $display("FAIL rand_ack c=%0d got %b%b want %b%b", c, bus.ack_a, bus.ack_b, m_ack[0], m_ack[1]); else pass_n++;
            tick();
            total_n++; if ({bus.busy, bus.sel, bus.out_valid} !== {owner >= 0, m_sel, m_ov}) $display("FAIL rand_state c=%0d got %b want %b", c, {bus.busy, bus.sel, bus.out_valid}, {owner >= 0, m_sel, m_ov}); else pass_n++;
            if (m_ov) begin
                total_n++; if (bus.out !== m_out) $display("FAIL rand_out c=%0d got %0h want %0h", c, bus.out, m_out); else pass_n++;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_alternate();
        test_max_burst();
        test_stall();
        test_abort();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
